sram_slot_arbiter: RTL and testbench
====================================

Name: sram_slot_arbiter

Overview:
- Time-slot scheduler for the single external 512Kx8 async SRAM, clocked by the pixel clock.
- Shares the SRAM between three requesters: the life engine read stream, the life engine write-back stream, and the CPU (1MHz bus) read/write port.
- Generates all SRAM control pins on a fixed 8-clock slot: two 4-clock sub-slots, A then B.
- Sits between the video/life pipeline, the 1MHz bus synchroniser and the SRAM pads.

Parameters:
- ADDR_W, 19, SRAM address width.
- DATA_W, 8, SRAM data width.
- IDLE_ADDR, all ones (ADDR_W bits), address driven when no access is in progress.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- phase_sync  in  1  forces the slot phase to 0 on the next edge; driven at the line/frame origin.
- eng_running  in  1  life engine owns sub-slot B; CPU is locked out while high.
- eng_rd_en  in  1  engine read request for the next sub-slot A.
- eng_rd_addr  in  ADDR_W  engine read address.
- eng_rd_data  out  DATA_W  engine read data.
- eng_rd_valid  out  1  one-cycle pulse; eng_rd_data is valid.
- eng_wr_en  in  1  engine write request for the next sub-slot B.
- eng_wr_addr  in  ADDR_W  engine write address.
- eng_wr_data  in  DATA_W  engine write data, already masked.
- cpu_req  in  1  CPU request, level, already synchronised to clk_pixel.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack and held until the next CPU read.
- ram_addr  out  ADDR_W  SRAM address.
- ram_dout  out  DATA_W  SRAM write data.
- ram_doe  out  1  data pad output enable.
- ram_din  in  DATA_W  SRAM data pad input.
- ram_cel, ram_oel, ram_wel  out  1 each  SRAM chip enable, output enable, write enable; all active low.

Behaviour:
- Phase counter: 3 bits, free-running 0..7, wraps 7->0.
  - Phases 0-3 are sub-slot A; phases 4-7 are sub-slot B.
  - phase_sync high: phase becomes 0 next cycle, regardless of current phase.
- Grant decision: registered on the edge entering phase 0 (for A) or phase 4 (for B), using the inputs present in phase 7 or phase 3 respectively.
  - A: engine read if eng_rd_en, else idle.
  - B: engine write if eng_wr_en && eng_running; else CPU if cpu_req && !eng_running; else idle.
  - A CPU grant in B is taken only when !eng_running, whatever eng_wr_en is.
- Access shape, by sub-phase s = phase[1:0]. All outputs are registered.
  - Read:
    - s0-s3: cel=0, oel=0, wel=1, doe=0, addr = granted address.
    - ram_din is captured on the edge ending s3.
    - eng_rd_valid or cpu_ack pulses for the one cycle after s3, with data.
  - Write:
    - s0-s3: cel=0, oel=1, addr held.
    - ram_dout is loaded at grant and held; doe=1 for s0-s3.
    - wel=0 in s1 and s2 only, so address and data are stable around the write pulse.
    - cpu_ack pulses for the one cycle after s3. Engine writes produce no acknowledge.
  - Idle: cel=oel=wel=1, doe=0, addr=IDLE_ADDR.
- CPU handshake:
  - cpu_req stays high until cpu_ack.
  - Exactly one access per request.
  - A req still high after ack is a new request, eligible no earlier than the next B.
- Abort:
  - phase_sync or rst during an access returns the pins to idle next cycle, with wel=1 immediately.
  - No valid or ack pulse is issued for the aborted access.
  - A pending CPU request stays pending and is retried.
- Reset values: phase=0; every SRAM control pin idle; eng_rd_valid=0; cpu_ack=0; eng_rd_data=0; cpu_rdata=0; ram_dout=0.
- Simultaneous requests:
  - eng_wr_en && eng_running && cpu_req: engine wins; CPU waits.
  - eng_running falling mid-slot does not affect the access in progress; it applies at the next B decision.

Optional Feature:
- Macro: SRAM_CPU_SLOT_A_EN.
- Defined: when eng_rd_en is low at the A decision point and cpu_req && !eng_running, the CPU is granted sub-slot A. This gives up to two CPU accesses per slot.
- Undefined: sub-slot A carries engine reads only.

Decomposition:
- Shared package life_pkg:
  - ADDR_W and DATA_W defaults.
  - Phase constants PH_A_START=0, PH_B_START=4.
  - Owner enum: IDLE, ENG_RD, ENG_WR, CPU_RD, CPU_WR.
  - IDLE_ADDR.
- One sub-module, sram_cycle_gen:
  - Takes owner and sub-phase.
  - Produces cel, oel, wel, doe and the capture strobe.
  - The arbiter keeps the phase counter, grant logic and handshakes.

Test Plan:
- Reset, then eng_rd_en=1 with addr 0x00010 and ram_din model returning 0xA5 -> cel/oel low in phases 0-3 only; eng_rd_valid pulse with 0xA5 in the cycle after phase 3.
- eng_running=1, eng_wr_en=1, addr 0x12345, data 0x3C -> wel low exactly in phases 5-6; doe high in 4-7; SRAM model holds 0x3C; no cpu_ack.
- eng_running=1 with cpu_req write pending -> no CPU access for 10 slots. Drop eng_running -> write completes in the next B; cpu_ack pulses once.
- eng_running=0, cpu_req read of addr 0x7FFFE holding 0x81 -> cpu_ack with cpu_rdata=0x81. req held high after ack -> second access no earlier than the next B.
- phase_sync asserted in phase 5 of a CPU write -> wel high the next cycle; no ack; request retried and acked in a later B.
- SRAM_CPU_SLOT_A_EN defined, eng_rd_en=0, eng_running=0, cpu_req read -> access occurs in phases 0-3. Undefined -> access occurs in phases 4-7.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the life engine / video SRAM datapath.
package life_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic [2:0] PH_A_START = 3'd0;
  localparam logic [2:0] PH_B_START = 3'd4;

  localparam logic [ADDR_W-1:0] IDLE_ADDR = '1;

  // owner  | meaning
  // IDLE   | no access, pins parked
  // ENG_RD | life engine read (sub-slot A)
  // ENG_WR | life engine write-back (sub-slot B)
  // CPU_RD | 1MHz bus read
  // CPU_WR | 1MHz bus write
  typedef enum logic [2:0] {
    IDLE,
    ENG_RD,
    ENG_WR,
    CPU_RD,
    CPU_WR
  } owner_t;

  function automatic logic is_read(owner_t o);
    return (o == ENG_RD) || (o == CPU_RD);
  endfunction

  function automatic logic is_write(owner_t o);
    return (o == ENG_WR) || (o == CPU_WR);
  endfunction

  function automatic logic is_cpu(owner_t o);
    return (o == CPU_RD) || (o == CPU_WR);
  endfunction

endpackage

// File: rtl/sram_cycle_gen.sv
// SRAM strobe shaping for one 4-clock sub-slot: maps owner and sub-phase to
// active-low controls, pad enable and the end-of-access strobes.
module sram_cycle_gen
  import life_pkg::*;
(
  input  owner_t     owner,
  input  logic [1:0] sub_phase,
  output logic       cel,
  output logic       oel,
  output logic       wel,
  output logic       doe,
  output logic       capture,
  output logic       last
);

  always_comb begin
    cel     = 1'b1;
    oel     = 1'b1;
    wel     = 1'b1;
    doe     = 1'b0;
    capture = 1'b0;
    last    = 1'b0;
    if (owner != IDLE) begin
      cel  = 1'b0;
      last = (sub_phase == 2'd3);
    end
    if (is_read(owner)) begin
      oel     = 1'b0;
      capture = (sub_phase == 2'd3);
    end
    if (is_write(owner)) begin
      doe = 1'b1;
      // write pulse sits inside the access so addr/data have setup and hold
      wel = !((sub_phase == 2'd1) || (sub_phase == 2'd2));
    end
  end

endmodule

// File: rtl/sram_slot_arbiter.sv
// 8-clock slot scheduler for the external async SRAM (A: engine read, B: engine
// write or CPU). SRAM_CPU_SLOT_A_EN lets the CPU use an unclaimed sub-slot A.
module sram_slot_arbiter #(
  parameter int ADDR_W = life_pkg::ADDR_W,
  parameter int DATA_W = life_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              phase_sync,
  input  logic              eng_running,
  input  logic              eng_rd_en,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic [DATA_W-1:0] eng_rd_data,
  output logic              eng_rd_valid,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_doe,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_cel,
  output logic              ram_oel,
  output logic              ram_wel
);

  import life_pkg::*;

  logic [2:0]        phase_q;
  logic [2:0]        phase_nxt;
  owner_t            owner_q;
  owner_t            owner_nxt;
  owner_t            cpu_own;
  logic              decide_a;
  logic              decide_b;
  logic              cpu_ok;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              cel_nxt;
  logic              oel_nxt;
  logic              wel_nxt;
  logic              doe_nxt;
  logic              cap_nxt;
  logic              last_nxt;
  logic              cap_q;
  logic              last_q;

  always_comb begin
    phase_nxt = phase_sync ? PH_A_START : phase_q + 3'd1;
    decide_a  = ((phase_q + 3'd1) == PH_A_START);
    decide_b  = ((phase_q + 3'd1) == PH_B_START);
    // a CPU access already in flight blocks a second grant for the same request
    cpu_ok    = cpu_req && !eng_running && !is_cpu(owner_q);
    cpu_own   = cpu_we ? CPU_WR : CPU_RD;

    owner_nxt = owner_q;
    if (phase_sync) begin
      owner_nxt = IDLE;
    end else if (decide_a) begin
      if (eng_rd_en) owner_nxt = ENG_RD;
`ifdef SRAM_CPU_SLOT_A_EN
      else if (cpu_ok) owner_nxt = cpu_own;
`endif
      else owner_nxt = IDLE;
    end else if (decide_b) begin
      if (eng_wr_en && eng_running) owner_nxt = ENG_WR;
      else if (cpu_ok)              owner_nxt = cpu_own;
      else                          owner_nxt = IDLE;
    end
  end

  always_comb begin
    addr_nxt = ram_addr;
    dout_nxt = ram_dout;
    if ((decide_a || decide_b) && !phase_sync) begin
      case (owner_nxt)
        ENG_RD: addr_nxt = eng_rd_addr;
        ENG_WR: begin
          addr_nxt = eng_wr_addr;
          dout_nxt = eng_wr_data;
        end
        CPU_RD: addr_nxt = cpu_addr;
        CPU_WR: begin
          addr_nxt = cpu_addr;
          dout_nxt = cpu_wdata;
        end
        default: addr_nxt = IDLE_ADDR;
      endcase
    end
    if (owner_nxt == IDLE) addr_nxt = IDLE_ADDR;
  end

  // Strobes are computed for the coming cycle so every pad output is a flop.
  sram_cycle_gen u_cycle_gen (
    .owner     (owner_nxt),
    .sub_phase (phase_nxt[1:0]),
    .cel       (cel_nxt),
    .oel       (oel_nxt),
    .wel       (wel_nxt),
    .doe       (doe_nxt),
    .capture   (cap_nxt),
    .last      (last_nxt)
  );

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      phase_q      <= PH_A_START;
      owner_q      <= IDLE;
      ram_cel      <= 1'b1;
      ram_oel      <= 1'b1;
      ram_wel      <= 1'b1;
      ram_doe      <= 1'b0;
      ram_addr     <= IDLE_ADDR;
      ram_dout     <= '0;
      cap_q        <= 1'b0;
      last_q       <= 1'b0;
      eng_rd_valid <= 1'b0;
      eng_rd_data  <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      phase_q      <= phase_nxt;
      owner_q      <= owner_nxt;
      ram_cel      <= cel_nxt;
      ram_oel      <= oel_nxt;
      ram_wel      <= wel_nxt;
      ram_doe      <= doe_nxt;
      ram_addr     <= addr_nxt;
      ram_dout     <= dout_nxt;
      cap_q        <= cap_nxt;
      last_q       <= last_nxt;
      // a sync on the closing edge aborts the access: no data, no handshake
      eng_rd_valid <= cap_q && (owner_q == ENG_RD) && !phase_sync;
      cpu_ack      <= last_q && is_cpu(owner_q) && !phase_sync;
      if (cap_q && !phase_sync) begin
        if (owner_q == ENG_RD) eng_rd_data <= ram_din;
        else                   cpu_rdata   <= ram_din;
      end
    end
  end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter with a behavioural async SRAM model.
// Expectations follow SRAM_CPU_SLOT_A_EN when the bench is built with it.
module tb_sram_slot_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam logic [3:0] PIN_IDLE = 4'b1110;  // {cel,oel,wel,doe}
  localparam logic [3:0] PIN_RD   = 4'b0010;
  localparam logic [3:0] PIN_WR   = 4'b0111;
  localparam logic [3:0] PIN_WP   = 4'b0101;

  logic          clk_pixel = 1'b0;
  logic          rst, phase_sync, eng_running, eng_rd_en, eng_wr_en, cpu_req, cpu_we;
  logic [AW-1:0] eng_rd_addr, eng_wr_addr, cpu_addr, ram_addr;
  logic [DW-1:0] eng_rd_data, eng_wr_data, cpu_wdata, cpu_rdata, ram_dout, ram_din;
  logic          eng_rd_valid, cpu_ack, ram_doe, ram_cel, ram_oel, ram_wel;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_asserts = 0;
  int n_fail    = 0;
  int tb_ph     = 0;

  sram_slot_arbiter dut (
    .clk_pixel    (clk_pixel),
    .rst          (rst),
    .phase_sync   (phase_sync),
    .eng_running  (eng_running),
    .eng_rd_en    (eng_rd_en),
    .eng_rd_addr  (eng_rd_addr),
    .eng_rd_data  (eng_rd_data),
    .eng_rd_valid (eng_rd_valid),
    .eng_wr_en    (eng_wr_en),
    .eng_wr_addr  (eng_wr_addr),
    .eng_wr_data  (eng_wr_data),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_dout     (ram_dout),
    .ram_doe      (ram_doe),
    .ram_din      (ram_din),
    .ram_cel      (ram_cel),
    .ram_oel      (ram_oel),
    .ram_wel      (ram_wel)
  );

  always #5 clk_pixel = ~clk_pixel;

  assign ram_din = (!ram_cel && !ram_oel) ? mem[ram_addr] : '0;

  always @(negedge clk_pixel)
    if (!ram_cel && !ram_wel && ram_doe) mem[ram_addr] = ram_dout;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic s;
    logic r;
    s = phase_sync;
    r = rst;
    @(posedge clk_pixel);
    #1;
    tb_ph = (r || s) ? 0 : (tb_ph + 1) % 8;
  endtask

  function automatic logic [3:0] pins();
    return {ram_cel, ram_oel, ram_wel, ram_doe};
  endfunction

  initial begin
    int n_ack, n_cel, ack1, ack2, cel_ph;
    rst = 1'b1; phase_sync = 1'b0; eng_running = 1'b0; eng_rd_en = 1'b0;
    eng_wr_en = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    eng_rd_addr = '0; eng_wr_addr = '0; cpu_addr = '0;
    eng_wr_data = '0; cpu_wdata = '0;
    mem[19'h00010] = 8'hA5;
    mem[19'h7FFFE] = 8'h81;
    mem[19'h00020] = 8'h4E;
    mem[19'h12345] = 8'h00;
    mem[19'h00400] = 8'h00;
    mem[19'h00777] = 8'h00;
    repeat (3) step();

    chk("rst_pins", pins(), PIN_IDLE);
    chk("rst_addr", ram_addr, 19'h7FFFF);
    chk("rst_rd_valid", eng_rd_valid, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_rd_data", eng_rd_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dout", ram_dout, 0);

    // engine read in sub-slot A
    rst = 1'b0;
    eng_rd_en = 1'b1; eng_rd_addr = 19'h00010;
    repeat (7) step();
    chk("rd_pre_pins_ph7", pins(), PIN_IDLE);
    step();
    eng_rd_en = 1'b0;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("rd_pins_ph%0d", p), pins(), (p < 4) ? PIN_RD : PIN_IDLE);
      chk($sformatf("rd_valid_ph%0d", p), eng_rd_valid, (p == 4));
      if (p < 4) chk($sformatf("rd_addr_ph%0d", p), ram_addr, 19'h00010);
      if (p == 4) chk("rd_data", eng_rd_data, 8'hA5);
      step();
    end

    // engine write in sub-slot B
    eng_running = 1'b1; eng_wr_en = 1'b1;
    eng_wr_addr = 19'h12345; eng_wr_data = 8'h3C;
    repeat (4) step();
    eng_wr_en = 1'b0;
    for (int p = 4; p < 8; p++) begin
      chk($sformatf("wr_pins_ph%0d", p), pins(), (p == 5 || p == 6) ? PIN_WP : PIN_WR);
      chk($sformatf("wr_addr_ph%0d", p), ram_addr, 19'h12345);
      chk($sformatf("wr_dout_ph%0d", p), ram_dout, 8'h3C);
      chk($sformatf("wr_noack_ph%0d", p), cpu_ack, 0);
      step();
    end
    chk("wr_after_pins", pins(), PIN_IDLE);
    chk("wr_after_noack", cpu_ack, 0);
    chk("wr_mem", mem[19'h12345], 8'h3C);

    // CPU write locked out while the engine runs
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00400; cpu_wdata = 8'h5A;
    n_ack = 0; n_cel = 0;
    repeat (80) begin
      step();
      n_ack += int'(cpu_ack);
      n_cel += int'(!ram_cel);
    end
    chk("lock_no_ack", n_ack, 0);
    chk("lock_no_access", n_cel, 0);
    eng_running = 1'b0;
    repeat (4) step();
    chk("cpuw_pins_ph4", pins(), PIN_WR);
    chk("cpuw_addr_ph4", ram_addr, 19'h00400);
    step();
    chk("cpuw_pins_ph5", pins(), PIN_WP);
    repeat (3) step();
    chk("cpuw_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    n_ack = 0;
    repeat (8) begin
      step();
      n_ack += int'(cpu_ack);
    end
    chk("cpuw_single_ack", n_ack, 0);
    chk("cpuw_mem", mem[19'h00400], 8'h5A);

    // CPU read, request held after the first ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h7FFFE;
    n_ack = 0; ack1 = -1; ack2 = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 5) begin
        chk("cpur_pins_k5", pins(), PIN_RD);
        chk("cpur_addr_k5", ram_addr, 19'h7FFFE);
      end
      if (cpu_ack) begin
        n_ack++;
        chk($sformatf("cpur_rdata_ack%0d", n_ack), cpu_rdata, 8'h81);
        if (n_ack == 1) ack1 = k;
        else begin
          ack2 = k;
          cpu_req = 1'b0;
        end
      end
    end
    chk("cpur_ack_count", n_ack, 2);
    chk("cpur_ack1_cycle", ack1, 8);
    chk("cpur_ack2_cycle", ack2, 16);

    // phase_sync aborts a CPU write mid-pulse; request is retried
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00777; cpu_wdata = 8'hC3;
    repeat (5) step();
    chk("abort_pins_ph5", pins(), PIN_WP);
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    chk("abort_pins_idle", pins(), PIN_IDLE);
    chk("abort_wel", ram_wel, 1);
    chk("abort_no_ack", cpu_ack, 0);
    n_ack = 0; ack1 = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (cpu_ack) begin
        n_ack++;
        if (ack1 < 0) ack1 = k;
        cpu_req = 1'b0;
      end
    end
    chk("retry_ack_count", n_ack, 1);
    chk("retry_ack_cycle", ack1, 8);
    chk("retry_mem", mem[19'h00777], 8'hC3);

    // CPU read raised after the B decision: slot A use depends on the build
    repeat (4) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00020;
    n_ack = 0; ack1 = -1; cel_ph = -1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (!ram_cel && cel_ph < 0) cel_ph = tb_ph;
      if (cpu_ack) begin
        n_ack++;
        if (ack1 < 0) ack1 = k;
        chk("slota_rdata", cpu_rdata, 8'h4E);
        cpu_req = 1'b0;
      end
    end
    chk("slota_ack_count", n_ack, 1);
`ifdef SRAM_CPU_SLOT_A_EN
    chk("slota_first_phase", cel_ph, 0);
    chk("slota_ack_cycle", ack1, 8);
`else
    chk("slota_first_phase", cel_ph, 4);
    chk("slota_ack_cycle", ack1, 12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
